// File: rtl/param_ser_pkg.sv
// Shared types and helpers for the parametrised serializer.
// Optional feature macro (used in the shifter): PARAM_SER_PARITY_EN.
// Word storage is sized for the widest supported word (MaxDataW). Narrower
// instances zero-extend into it.
package param_ser_pkg;

  localparam int unsigned MaxDataW = 128;
  localparam int unsigned LenW     = 8;

  typedef logic [LenW-1:0]     len_t;
  typedef logic [MaxDataW-1:0] data_t;

  // A word as handed from the buffer logic to the shifter.
  typedef struct packed {
    data_t data;
    len_t  len;
  } word_t;

  // Shifter state.
  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } shift_state_e;

  // A length field of zero stands for a full-width word.
  function automatic len_t mod_to_len(input len_t mod, input len_t data_w);
    return (mod == '0) ? data_w : mod;
  endfunction

endpackage

// File: rtl/param_ser_shifter.sv
// Output shift stage: holds the word being emitted, counts the remaining bits
// and drives the registered serial outputs.
// Macro PARAM_SER_PARITY_EN appends an even-parity bit after each word.
module param_ser_shifter
  import param_ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic  clk_i,
  input  logic  srst_i,
  input  logic  load_i,
  input  word_t word_i,
  output logic  take_o,
  output logic  ser_data_o,
  output logic  ser_data_val_o,
  output logic  ser_last_o
);

`ifdef PARAM_SER_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  shift_state_e      r_state;
  logic [DATA_W-1:0] r_sreg;   // bits still to emit, next one at the exit end
  len_t              r_rem;    // data bits left after the one on the output
  logic              r_ser;
  logic              r_last;

  len_t              w_pad;
  logic [DATA_W-1:0] w_aligned;
  logic              w_load_first;
  logic [DATA_W-1:0] w_load_rest;
  logic              w_shift_bit;
  logic [DATA_W-1:0] w_shift_rest;
  logic              w_par_bit;

  // Align a fresh word so its first bit sits at the exit end of the register;
  // bits above len fall off the top (MSB-first) or are never reached.
  always_comb begin
    w_pad = len_t'(DATA_W) - word_i.len;
    if (MSB_FIRST != 0) begin
      w_aligned    = DATA_W'(word_i.data << w_pad);
      w_load_first = w_aligned[DATA_W-1];
      w_load_rest  = w_aligned << 1;
      w_shift_bit  = r_sreg[DATA_W-1];
      w_shift_rest = r_sreg << 1;
    end else begin
      w_aligned    = DATA_W'(word_i.data);
      w_load_first = w_aligned[0];
      w_load_rest  = w_aligned >> 1;
      w_shift_bit  = r_sreg[0];
      w_shift_rest = r_sreg >> 1;
    end
  end

`ifdef PARAM_SER_PARITY_EN
  logic r_par;
  logic w_load_par;

  // Even parity over the len data bits of the word being loaded.
  always_comb begin
    w_load_par = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (len_t'(i) < word_i.len) w_load_par = w_load_par ^ word_i.data[i];
    end
  end

  // Parity is latched with the word and emitted after its last data bit.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_par <= 1'b0;
    end else if (load_i) begin
      r_par <= w_load_par;
    end
  end

  assign w_par_bit = r_par;
`else
  assign w_par_bit = 1'b0;
`endif

  // Load, shift, or retire; a load on the last-bit cycle continues seamlessly.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= StIdle;
      r_sreg  <= '0;
      r_rem   <= '0;
      r_ser   <= 1'b0;
      r_last  <= 1'b0;
    end else if (load_i) begin
      r_state <= StShift;
      r_sreg  <= w_load_rest;
      r_rem   <= word_i.len - len_t'(1);
      r_ser   <= w_load_first;
      r_last  <= (word_i.len == len_t'(1)) && !ParityEn;
    end else if (r_state == StShift) begin
      if (r_last) begin
        r_state <= StIdle;
        r_ser   <= 1'b0;
        r_last  <= 1'b0;
      end else if (r_rem != '0) begin
        r_sreg  <= w_shift_rest;
        r_ser   <= w_shift_bit;
        r_rem   <= r_rem - len_t'(1);
        r_last  <= (r_rem == len_t'(1)) && !ParityEn;
      end else begin
        // Only reachable with parity enabled: data done, parity bit next.
        r_ser   <= w_par_bit;
        r_last  <= 1'b1;
      end
    end
  end

  assign take_o         = (r_state == StIdle) || r_last;
  assign ser_data_o     = r_ser;
  assign ser_data_val_o = (r_state == StShift);
  assign ser_last_o     = r_last;

endmodule

// File: rtl/param_serializer.sv
// Double-buffered parallel-to-serial converter: accept/reject decision,
// one-word holding buffer and the busy/drop flags around the shift stage.
// Macro PARAM_SER_PARITY_EN (handled in the shifter) adds a parity bit per word.
module param_serializer
  import param_ser_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MOD_W     = $clog2(DATA_W),
  parameter int unsigned MIN_LEN   = 3,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_last_o,
  output logic              busy_o,
  output logic              drop_o
);

  word_t r_hold;
  logic  r_busy;   // hold register occupied
  logic  r_drop;

  len_t  w_len;
  logic  w_legal;
  logic  w_accept;
  logic  w_drop;
  logic  w_take;
  logic  w_load;
  logic  w_to_hold;
  word_t w_in_word;
  word_t w_load_word;

  // Classify the presented word and decide where an accepted one goes.
  always_comb begin
    w_len            = mod_to_len(len_t'(data_mod_i), len_t'(DATA_W));
    w_legal          = (w_len >= len_t'(MIN_LEN));
    w_accept         = data_val_i && !r_busy && w_legal;
    w_drop           = data_val_i && (r_busy || !w_legal);
    w_in_word.data   = data_t'(data_i);
    w_in_word.len    = w_len;
    // A full hold always has priority; it only fills while the shifter is busy.
    w_load           = w_take && (r_busy || w_accept);
    w_load_word      = r_busy ? r_hold : w_in_word;
    w_to_hold        = w_accept && !w_take;
  end

  // Hold register and the busy/drop flags.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_hold <= '0;
      r_busy <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_to_hold) begin
        r_hold <= w_in_word;
        r_busy <= 1'b1;
      end else if (w_take && r_busy) begin
        r_busy <= 1'b0;
      end
    end
  end

  param_ser_shifter #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .load_i         (w_load),
    .word_i         (w_load_word),
    .take_o         (w_take),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .ser_last_o     (ser_last_o)
  );

  assign busy_o = r_busy;
  assign drop_o = r_drop;

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: an MSB-first and an LSB-first instance share the
// same stimulus; a stream-of-bits model predicts every output each cycle.
module tb_param_serializer;

`ifdef PARAM_SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int MinLen = 3;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  data_mod = '0;
  logic        data_val = 1'b0;
  logic        m_ser, m_val, m_last, m_busy, m_drop;
  logic        l_ser, l_val, l_last, l_busy, l_drop;

  always #5 clk = ~clk;

  param_serializer #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(1)) u_dut (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_mod_i(data_mod), .data_val_i(data_val),
    .ser_data_o(m_ser), .ser_data_val_o(m_val), .ser_last_o(m_last), .busy_o(m_busy),
    .drop_o(m_drop)
  );

  param_serializer #(.DATA_W(16), .MIN_LEN(3), .MSB_FIRST(0)) u_dut_lsb (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_mod_i(data_mod), .data_val_i(data_val),
    .ser_data_o(l_ser), .ser_data_val_o(l_val), .ser_last_o(l_last), .busy_o(l_busy),
    .drop_o(l_drop)
  );

  // Model: the queue holds every bit still owed to the line, in emission order.
  typedef struct packed {
    logic bm;    // bit for MSB-first order
    logic bl;    // bit for LSB-first order
    logic last;
  } ent_t;

  ent_t exp_q[$];
  logic exp_drop = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic obs_val, obs_bit, obs_lbit, obs_last, obs_busy, obs_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int words_pending();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].last) n++;
    return n;
  endfunction

  function automatic int len_of(input logic [3:0] m);
    return (m == 4'd0) ? 16 : int'(m);
  endfunction

  task automatic push_word(input logic [15:0] d, input logic [3:0] m);
    int   len;
    logic par;
    ent_t e;
    len = len_of(m);
    par = 1'b0;
    for (int k = 0; k < len; k++) begin
      e.bm   = d[len-1-k];
      e.bl   = d[k];
      e.last = (k == len - 1) && (P == 0);
      par    = par ^ d[k];
      exp_q.push_back(e);
    end
    if (P != 0) begin
      e.bm = par; e.bl = par; e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic cycle(input logic rst, input logic v, input logic [15:0] d,
                       input logic [3:0] m);
    logic busy_now, legal;
    ent_t h;
    srst = rst; data_val = v; data = d; data_mod = m;
    @(negedge clk);
    busy_now = (words_pending() >= 2);
    h = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("msb_val",  m_val,  exp_q.size() > 0);
    chk("msb_data", m_ser,  h.bm);
    chk("msb_last", m_last, h.last);
    chk("msb_busy", m_busy, busy_now);
    chk("msb_drop", m_drop, exp_drop);
    chk("lsb_val",  l_val,  exp_q.size() > 0);
    chk("lsb_data", l_ser,  h.bl);
    chk("lsb_last", l_last, h.last);
    chk("lsb_busy", l_busy, busy_now);
    chk("lsb_drop", l_drop, exp_drop);
    obs_val = m_val; obs_bit = m_ser; obs_lbit = l_ser; obs_last = m_last;
    obs_busy = m_busy; obs_drop = m_drop;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_drop = 1'b0;
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      legal    = (len_of(m) >= MinLen);
      exp_drop = v && (busy_now || !legal);
      if (v && !busy_now && legal) push_word(d, m);
    end
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
    int          len;       // data bits expected, 0 when dropped
    logic [15:0] exp_msb;   // MSB-first stream, first bit in bit 15
    logic [15:0] exp_lsb;   // LSB-first stream, first bit in bit 15
    logic        exp_drop;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int          idx, last_pos, nval, first_c, last_c;
    logic        saw_drop, par;
    logic [15:0] gm, gl;
    logic [15:0] got16;

    tbl[0]  = '{16'hA5C3, 4'd0,  16, 16'hA5C3, 16'hC3A5, 1'b0};
    tbl[1]  = '{16'h00F0, 4'd8,   8, 16'hF000, 16'h0F00, 1'b0};
    tbl[2]  = '{16'hFFFF, 4'd4,   4, 16'hF000, 16'hF000, 1'b0};
    tbl[3]  = '{16'h0001, 4'd4,   4, 16'h1000, 16'h8000, 1'b0};
    tbl[4]  = '{16'h1234, 4'd3,   3, 16'h8000, 16'h2000, 1'b0};
    tbl[5]  = '{16'h0005, 4'd15, 15, 16'h000A, 16'hA000, 1'b0};
    tbl[6]  = '{16'hFFFF, 4'd5,   5, 16'hF800, 16'hF800, 1'b0};
    tbl[7]  = '{16'h8000, 4'd0,  16, 16'h8000, 16'h0001, 1'b0};
    tbl[8]  = '{16'h0007, 4'd3,   3, 16'hE000, 16'hE000, 1'b0};
    tbl[9]  = '{16'hFFFF, 4'd2,   0, 16'h0000, 16'h0000, 1'b1};
    tbl[10] = '{16'hFFFF, 4'd1,   0, 16'h0000, 16'h0000, 1'b1};
    tbl[11] = '{16'h5A5A, 4'd12, 12, 16'hA5A0, 16'h5A50, 1'b0};

    repeat (2) @(posedge clk);
    #1;

    // Reset state, then 20 quiet cycles.
    nval = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 4'h0);
      if (obs_val || obs_last || obs_bit || obs_busy || obs_drop) nval++;
    end
    chk("reset_quiet", nval, 0);

    // Single words from the table.
    foreach (tbl[t]) begin
      idle(2);
      cycle(1'b0, 1'b1, tbl[t].d, tbl[t].m);
      gm = '0; gl = '0; idx = 0; last_pos = -1; saw_drop = 1'b0; par = 1'b0;
      for (int c = 0; c < 20; c++) begin
        cycle(1'b0, 1'b0, 16'h0, 4'h0);
        if (c == 0) saw_drop = obs_drop;
        if (obs_val) begin
          if (idx < tbl[t].len) begin
            gm[15-idx] = obs_bit;
            gl[15-idx] = obs_lbit;
          end else begin
            par = obs_bit;
          end
          if (obs_last) last_pos = idx;
          idx++;
        end
      end
      chk("tbl_msb_bits", gm, tbl[t].exp_msb);
      chk("tbl_lsb_bits", gl, tbl[t].exp_lsb);
      chk("tbl_count", idx, (tbl[t].len > 0) ? tbl[t].len + P : 0);
      chk("tbl_last_pos", last_pos, (tbl[t].len > 0) ? tbl[t].len + P - 1 : -1);
      chk("tbl_drop", saw_drop, tbl[t].exp_drop);
      if (P != 0 && tbl[t].len > 0) chk("tbl_parity", par, ^tbl[t].exp_msb);
    end

    // Back-to-back words, third word dropped while the hold is full.
    idle(2);
    got16 = '0; nval = 0; first_c = -1; last_c = -1;
    cycle(1'b0, 1'b1, 16'h00F0, 4'd8);
    for (int c = 0; c < 18; c++) begin
      if (c == 0)      cycle(1'b0, 1'b1, 16'hFFFF, 4'd4);
      else if (c == 1) cycle(1'b0, 1'b1, 16'h1234, 4'd0);
      else             cycle(1'b0, 1'b0, 16'h0, 4'h0);
      if (c == 1) chk("b2b_busy", obs_busy, 1);
      if (c == 2) chk("b2b_drop", obs_drop, 1);
      if (obs_val) begin
        got16 = {got16[14:0], obs_bit};
        nval++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    chk("b2b_count", nval, 12 + 2 * P);
    chk("b2b_no_gap", last_c - first_c + 1, nval);
    chk("b2b_bits", got16, (P != 0) ? 16'b0011110000011110 : 16'h0F0F);

    // New word presented on the last-bit cycle goes straight to the shifter.
    idle(2);
    cycle(1'b0, 1'b1, 16'h000F, 4'd4);
    idle(3 + P);
    cycle(1'b0, 1'b1, 16'h0000, 4'd4);
    chk("edge_last", obs_last, 1);
    chk("edge_busy", obs_busy, 0);
    cycle(1'b0, 1'b0, 16'h0, 4'h0);
    chk("edge_cont_val", obs_val, 1);
    chk("edge_cont_busy", obs_busy, 0);
    chk("edge_cont_drop", obs_drop, 0);
    idle(8);

    // Reset mid-word with the hold full.
    cycle(1'b0, 1'b1, 16'hA5C3, 4'd0);
    cycle(1'b0, 1'b1, 16'hFFFF, 4'd4);
    idle(4);
    cycle(1'b1, 1'b0, 16'h0, 4'h0);
    chk("rst_busy_before", obs_busy, 1);
    nval = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 4'h0);
      if (obs_val || obs_busy) nval++;
    end
    chk("rst_quiet", nval, 0);
    cycle(1'b0, 1'b1, 16'h8000, 4'd0);
    cycle(1'b0, 1'b0, 16'h0, 4'h0);
    chk("rst_restart_val", obs_val, 1);
    chk("rst_restart_bit", obs_bit, 1);
    idle(18);

    // Random traffic against the model, with the odd reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 45),
            16'($urandom), 4'($urandom_range(0, 15)));
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_serializer.md
# param_serializer

Parametrised, double-buffered parallel-to-serial converter, successor to the fixed 16-bit serializer. Each accepted word of `DATA_W` bits is emitted one bit per clock, with a per-word length (`data_mod_i`) and a selectable bit order. A one-word holding buffer lets consecutive words stream with no idle cycle between them. It sits between a parallel producer and a single-wire serial sink on the same clock.

## Interface
Parameters:
- `DATA_W`, 16: word width; power of two, ≥ 4.
- `MOD_W`, `$clog2(DATA_W)`: width of the length field.
- `MIN_LEN`, 3: shortest legal length; values 1..`MIN_LEN`-1 are rejected. Must be ≥ 1.
- `MSB_FIRST`, 1: 1 = bit `len-1` first, down to bit 0; 0 = bit 0 first, up to bit `len-1`.

Ports:
- `clk_i` in 1: clock; all logic on rising edge.
- `srst_i` in 1: synchronous, active-high reset.
- `data_i` in `DATA_W`: parallel word.
- `data_mod_i` in `MOD_W`: number of bits to send; 0 means `DATA_W`.
- `data_val_i` in 1: `data_i`/`data_mod_i` valid this cycle.
- `ser_data_o` out 1: serial bit; 0 whenever `ser_data_val_o`=0.
- `ser_data_val_o` out 1: `ser_data_o` valid.
- `ser_last_o` out 1: final bit of the current word (including parity bit when enabled).
- `busy_o` out 1: holding buffer full; new words are not accepted.
- `drop_o` out 1: one-cycle pulse, the cycle after a presented word was discarded.

## Operation
- Accept when `data_val_i`=1 and `busy_o`=0, and len legal, where len = `data_mod_i` (0 → `DATA_W`).
- If len is in 1..`MIN_LEN`-1: discard, pulse `drop_o`, no state change.
- If `data_val_i`=1 while `busy_o`=1: discard, pulse `drop_o`.
- Accepted word routing:
  - Shifter idle, or shifter emitting its last bit this cycle with hold empty → load shifter.
  - Otherwise → load hold.
- Hold transfers to the shifter on the cycle the shifter emits its last bit.
- Shifter states:
  - IDLE → SHIFT on load.
  - SHIFT → SHIFT while the bit counter is above 1.
  - On the last bit: reload (SHIFT) if hold full or a new word is accepted; else IDLE.
- Bits above len in `data_i` are ignored.
- Reset mid-word aborts immediately. The partial word is lost, the hold is cleared, and nothing is emitted after reset.

## Timing
- All outputs registered. Reset values: `ser_data_o`=0, `ser_data_val_o`=0, `ser_last_o`=0, `busy_o`=0, `drop_o`=0.
- Latency: word accepted at edge N into an idle shifter → first bit valid in cycle N+1. A len-L word occupies cycles N+1..N+L contiguously, with `ser_last_o` in cycle N+L.
- Back-to-back: a held word's first bit is in the cycle right after the previous word's last bit; `ser_data_val_o` never drops between them.
- `busy_o` rises the cycle after a word enters the hold. It falls the cycle after the hold transfers, so a word presented in that cycle is accepted.
- A word presented in the same cycle the shifter emits its last bit with hold empty goes straight to the shifter; no gap, `busy_o` stays 0.
- Sustained throughput: one word per L cycles, 100 % line utilisation.

## Configuration
- `PARAM_SER_PARITY_EN` defined: after the last data bit, one extra bit equal to the XOR of the len data bits (even parity) is emitted with `ser_data_val_o`=1. `ser_last_o` moves to the parity bit, and words occupy L+1 cycles.
- Undefined: no parity logic; exactly L bits per word.

## Structure
- Package `param_ser_pkg`:
  - `len_t` typedef.
  - `word_t` struct {data, len}.
  - Function converting `data_mod_i` to len (0 → `DATA_W`).
  - Shifter state enum {IDLE, SHIFT}.
- Sub-module `param_ser_shifter`: shift register, bit counter, state, optional parity bit, serial outputs.
- Top `param_serializer`: accept/reject logic, hold register, `busy_o`, `drop_o`.

## Test plan
(`DATA_W`=16, `MIN_LEN`=3, `MSB_FIRST`=1 unless noted)
- Reset then idle → all outputs 0 for 20 cycles.
- `data_i`=16'hA5C3, mod 0 at edge N → bits 1010_0101_1100_0011 in cycles N+1..N+16; `ser_last_o` only at N+16.
- 16'h00F0 mod 8 followed immediately by 16'hFFFF mod 4 → 8 bits 1111_0000, then 1111 with no gap. `busy_o`=1 from N+2 until the hold transfers.
- Mod 2 presented → `drop_o` pulses once, no serial output. Third word while `busy_o`=1 → `drop_o`, word absent from output.
- `MSB_FIRST`=0, 16'h0001 mod 4 → 1,0,0,0. With `PARAM_SER_PARITY_EN`: 16'h0007 mod 3 → 1,1,1, then parity 1 flagged `ser_last_o`.
- `srst_i` pulsed mid-word (bit 5 of 16) with hold full → `ser_data_val_o`=0 the cycle after reset and stays 0. The next word starts cleanly.
